// File: rtl/gb_noise_regs.sv
`default_nettype none
// ============================================================================
//  Module   : gb_noise_regs
//  Purpose  : CPU-visible register file for the Game Boy noise channel
//             (NR41..NR44 at 0xFF20..0xFF23). Decodes bus writes, exposes the
//             stored fields to the channel, generates the one-cycle trigger
//             (start) and length-reload (length_load) pulses, and provides
//             registered read-back with the hardware's unreadable bits forced
//             high.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             apu_on              - NR52 power bit (0 clears and locks regs)
//             addr/wr/rd/wdata    - CPU bus
//             rdata               - registered read data
//             length .. single    - decoded register fields to the channel
//             start, length_load  - one-cycle pulses to the channel
//             dac_on              - channel DAC enable from NR42[7:3]
//  Revision : 1.0 - initial release
// ============================================================================
module gb_noise_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic        apu_on,
    input  logic [15:0] addr,
    input  logic        wr,
    input  logic        rd,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic [5:0]  length,
    output logic [3:0]  initial_volume,
    output logic        envelope_increasing,
    output logic [2:0]  num_envelope_sweeps,
    output logic [3:0]  shift_clock_freq,
    output logic        counter_width,
    output logic [2:0]  freq_dividing_ratio,
    output logic        single,
    output logic        start,
    output logic        length_load,
    output logic        dac_on
);

    // Upper 14 address bits shared by 0xFF20..0xFF23
    localparam logic [13:0] REG_BASE = 14'h3FC8;
    localparam logic [1:0]  IDX_NR41 = 2'd0;
    localparam logic [1:0]  IDX_NR42 = 2'd1;
    localparam logic [1:0]  IDX_NR43 = 2'd2;
    localparam logic [1:0]  IDX_NR44 = 2'd3;

    logic [5:0] nr41_q, nr41_d;
    logic [7:0] nr42_q, nr42_d;
    logic [7:0] nr43_q, nr43_d;
    logic       single_q, single_d;
    logic       start_q, start_d;
    logic       length_load_q, length_load_d;
    logic [7:0] rdata_q, rdata_d;

    logic       w_in_range;
    logic       w_wr_ok;
    logic       w_dac_on;
    logic [7:0] w_nr42_vis;
    logic [7:0] w_nr43_vis;
    logic       w_single_vis;
    logic [7:0] w_rd_val;

    assign w_in_range = (addr[15:2] == REG_BASE);
    assign w_wr_ok    = wr && apu_on && w_in_range;
    assign w_dac_on   = |nr42_q[7:3];

    // While powered off the registers are being forced to zero, so reads
    // return the cleared values even in the first powered-off cycle.
    assign w_nr42_vis   = apu_on ? nr42_q   : 8'h00;
    assign w_nr43_vis   = apu_on ? nr43_q   : 8'h00;
    assign w_single_vis = apu_on ? single_q : 1'b0;

    // Read mux works on the stored (pre-write) values, so a same-cycle
    // write and read of one register returns the old contents.
    always_comb begin
        w_rd_val = 8'hFF;
        if (w_in_range) begin
            case (addr[1:0])
                IDX_NR41: w_rd_val = 8'hFF;
                IDX_NR42: w_rd_val = w_nr42_vis;
                IDX_NR43: w_rd_val = w_nr43_vis;
                IDX_NR44: w_rd_val = {1'b1, w_single_vis, 6'b111111};
                default:  w_rd_val = 8'hFF;
            endcase
        end
    end

    always_comb begin
        nr41_d        = nr41_q;
        nr42_d        = nr42_q;
        nr43_d        = nr43_q;
        single_d      = single_q;
        start_d       = 1'b0;
        length_load_d = 1'b0;
        rdata_d       = rdata_q;

        if (rd) begin
            rdata_d = w_rd_val;
        end

        if (!apu_on) begin
            nr41_d   = 6'd0;
            nr42_d   = 8'd0;
            nr43_d   = 8'd0;
            single_d = 1'b0;
        end else if (w_wr_ok) begin
            case (addr[1:0])
                IDX_NR41: begin
                    nr41_d        = wdata[5:0];
                    length_load_d = 1'b1;
                end
                IDX_NR42: nr42_d = wdata;
                IDX_NR43: nr43_d = wdata;
                IDX_NR44: begin
                    single_d = wdata[6];
                    // Only one write per cycle, so NR42 cannot change
                    // alongside an NR44 write: the current DAC state is the
                    // post-write state.
                    start_d  = wdata[7] && w_dac_on;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nr41_q        <= 6'd0;
            nr42_q        <= 8'd0;
            nr43_q        <= 8'd0;
            single_q      <= 1'b0;
            start_q       <= 1'b0;
            length_load_q <= 1'b0;
            rdata_q       <= 8'h00;
        end else begin
            nr41_q        <= nr41_d;
            nr42_q        <= nr42_d;
            nr43_q        <= nr43_d;
            single_q      <= single_d;
            start_q       <= start_d;
            length_load_q <= length_load_d;
            rdata_q       <= rdata_d;
        end
    end

    // A pulse already scheduled when reset arrives is suppressed for the
    // whole reset cycle, so the channel never sees a trigger that reset
    // was meant to cancel.
    assign start       = start_q && !reset;
    assign length_load = length_load_q && !reset;

    assign rdata               = rdata_q;
    assign length              = nr41_q;
    assign initial_volume      = nr42_q[7:4];
    assign envelope_increasing = nr42_q[3];
    assign num_envelope_sweeps = nr42_q[2:0];
    assign shift_clock_freq    = nr43_q[7:4];
    assign counter_width       = nr43_q[3];
    assign freq_dividing_ratio = nr43_q[2:0];
    assign single              = single_q;
    assign dac_on              = w_dac_on;

endmodule
`default_nettype wire

// File: tb/tb_gb_noise_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gb_noise_regs
//  Purpose  : Self-checking bench for gb_noise_regs: directed vector table,
//             hand-written reset-cancel sequence and randomized traffic
//             checked against a behavioural register model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gb_noise_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        apu_on = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic [5:0]  length;
    logic [3:0]  initial_volume;
    logic        envelope_increasing;
    logic [2:0]  num_envelope_sweeps;
    logic [3:0]  shift_clock_freq;
    logic        counter_width;
    logic [2:0]  freq_dividing_ratio;
    logic        single;
    logic        start;
    logic        length_load;
    logic        dac_on;

    gb_noise_regs dut (
        .clk                 (clk),
        .reset               (reset),
        .apu_on              (apu_on),
        .addr                (addr),
        .wr                  (wr),
        .rd                  (rd),
        .wdata               (wdata),
        .rdata               (rdata),
        .length              (length),
        .initial_volume      (initial_volume),
        .envelope_increasing (envelope_increasing),
        .num_envelope_sweeps (num_envelope_sweeps),
        .shift_clock_freq    (shift_clock_freq),
        .counter_width       (counter_width),
        .freq_dividing_ratio (freq_dividing_ratio),
        .single              (single),
        .start               (start),
        .length_load         (length_load),
        .dac_on              (dac_on)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ------------------------------------------------------------------
    // Behavioural model: four byte registers with per-register store masks
    // ------------------------------------------------------------------
    logic [7:0] m_reg [4];
    logic       m_start;
    logic       m_ll;
    logic [7:0] m_rdata;

    function automatic logic [7:0] store_mask(input int idx);
        case (idx)
            0:       return 8'h3F;
            3:       return 8'h40;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int reg_index(input logic [15:0] a);
        if (a >= 16'hFF20 && a <= 16'hFF23) return int'(a - 16'hFF20);
        return -1;
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] a, input logic on);
        int idx;
        logic [7:0] v;
        idx = reg_index(a);
        if (idx < 0 || idx == 0) return 8'hFF;
        v = on ? m_reg[idx] : 8'h00;
        if (idx == 3) return v | 8'hBF;
        return v;
    endfunction

    task automatic model_step();
        int idx;
        if (reset) begin
            for (int k = 0; k < 4; k++) m_reg[k] = 8'h00;
            m_start = 1'b0;
            m_ll    = 1'b0;
            m_rdata = 8'h00;
            return;
        end
        if (rd) m_rdata = model_read(addr, apu_on);
        m_start = 1'b0;
        m_ll    = 1'b0;
        if (!apu_on) begin
            for (int k = 0; k < 4; k++) m_reg[k] = 8'h00;
            return;
        end
        idx = reg_index(addr);
        if (wr && idx >= 0) begin
            m_reg[idx] = wdata & store_mask(idx);
            if (idx == 0) m_ll = 1'b1;
            if (idx == 3 && wdata[7] && m_reg[1] >= 8'd8) m_start = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model rdata",   16'(rdata), 16'(m_rdata));
        chk("model start",   16'(start), 16'(m_start && !reset));
        chk("model lenload", 16'(length_load), 16'(m_ll && !reset));
        chk("model dac_on",  16'(dac_on), 16'(m_reg[1] >= 8'd8));
        chk("model length",  16'(length), 16'(m_reg[0]));
        chk("model NR42",    16'({initial_volume, envelope_increasing, num_envelope_sweeps}),
                             16'(m_reg[1]));
        chk("model NR43",    16'({shift_clock_freq, counter_width, freq_dividing_ratio}),
                             16'(m_reg[2]));
        chk("model single",  16'(single), 16'(m_reg[3] != 8'h00));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst, apu, w, r;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  e_rdata;
        logic        e_start, e_ll, e_dac, e_single;
        logic [3:0]  e_vol;
        logic [5:0]  e_len;
    } vec_t;

    function automatic vec_t mk(input logic rst_, input logic apu_, input logic w_,
                                input logic r_, input logic [15:0] a_, input logic [7:0] d_,
                                input logic [7:0] er, input logic es, input logic el,
                                input logic ed, input logic esg, input logic [3:0] ev,
                                input logic [5:0] eln);
        vec_t v;
        v.rst = rst_; v.apu = apu_; v.w = w_; v.r = r_; v.a = a_; v.d = d_;
        v.e_rdata = er; v.e_start = es; v.e_ll = el; v.e_dac = ed;
        v.e_single = esg; v.e_vol = ev; v.e_len = eln;
        return v;
    endfunction

    vec_t vt [32];

    initial begin
        //            rst apu wr rd addr      wd     rdata st ll dac sg vol  len
        vt[0]  = mk(1, 1, 0, 0, 16'hFF20, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 6'h00);
        vt[1]  = mk(0, 1, 1, 0, 16'hFF21, 8'h19, 8'h00, 0, 0, 1, 0, 4'h1, 6'h00);
        vt[2]  = mk(0, 1, 1, 0, 16'hFF22, 8'h00, 8'h00, 0, 0, 1, 0, 4'h1, 6'h00);
        vt[3]  = mk(0, 1, 1, 0, 16'hFF23, 8'hC0, 8'h00, 1, 0, 1, 1, 4'h1, 6'h00);
        vt[4]  = mk(0, 1, 0, 0, 16'hFF23, 8'h00, 8'h00, 0, 0, 1, 1, 4'h1, 6'h00);
        vt[5]  = mk(0, 1, 1, 0, 16'hFF21, 8'h07, 8'h00, 0, 0, 0, 1, 4'h0, 6'h00);
        vt[6]  = mk(0, 1, 1, 0, 16'hFF23, 8'h80, 8'h00, 0, 0, 0, 0, 4'h0, 6'h00);
        vt[7]  = mk(0, 1, 0, 0, 16'hFF23, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 6'h00);
        vt[8]  = mk(0, 1, 1, 0, 16'hFF21, 8'h08, 8'h00, 0, 0, 1, 0, 4'h0, 6'h00);
        vt[9]  = mk(0, 1, 1, 0, 16'hFF23, 8'h80, 8'h00, 1, 0, 1, 0, 4'h0, 6'h00);
        vt[10] = mk(0, 1, 0, 0, 16'hFF23, 8'h00, 8'h00, 0, 0, 1, 0, 4'h0, 6'h00);
        vt[11] = mk(0, 1, 1, 0, 16'hFF20, 8'hE8, 8'h00, 0, 1, 1, 0, 4'h0, 6'h28);
        vt[12] = mk(0, 1, 0, 0, 16'hFF20, 8'h00, 8'h00, 0, 0, 1, 0, 4'h0, 6'h28);
        vt[13] = mk(0, 1, 0, 1, 16'hFF20, 8'h00, 8'hFF, 0, 0, 1, 0, 4'h0, 6'h28);
        vt[14] = mk(0, 1, 0, 1, 16'hFF23, 8'h00, 8'hBF, 0, 0, 1, 0, 4'h0, 6'h28);
        vt[15] = mk(0, 1, 1, 0, 16'hFF23, 8'h40, 8'hBF, 0, 0, 1, 1, 4'h0, 6'h28);
        vt[16] = mk(0, 1, 0, 1, 16'hFF23, 8'h00, 8'hFF, 0, 0, 1, 1, 4'h0, 6'h28);
        vt[17] = mk(0, 1, 1, 0, 16'hFF22, 8'h19, 8'hFF, 0, 0, 1, 1, 4'h0, 6'h28);
        vt[18] = mk(0, 1, 1, 1, 16'hFF22, 8'hA5, 8'h19, 0, 0, 1, 1, 4'h0, 6'h28);
        vt[19] = mk(0, 1, 0, 1, 16'hFF22, 8'h00, 8'hA5, 0, 0, 1, 1, 4'h0, 6'h28);
        vt[20] = mk(0, 1, 0, 1, 16'hFF30, 8'h00, 8'hFF, 0, 0, 1, 1, 4'h0, 6'h28);
        vt[21] = mk(0, 0, 0, 0, 16'hFF22, 8'h00, 8'hFF, 0, 0, 0, 0, 4'h0, 6'h00);
        vt[22] = mk(0, 0, 1, 0, 16'hFF22, 8'h5A, 8'hFF, 0, 0, 0, 0, 4'h0, 6'h00);
        vt[23] = mk(0, 1, 0, 0, 16'hFF22, 8'h00, 8'hFF, 0, 0, 0, 0, 4'h0, 6'h00);
        vt[24] = mk(0, 1, 0, 1, 16'hFF22, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 6'h00);
        vt[25] = mk(0, 1, 1, 0, 16'hFF20, 8'hE8, 8'h00, 0, 1, 0, 0, 4'h0, 6'h28);
        vt[26] = mk(0, 1, 1, 0, 16'hFF20, 8'hE8, 8'h00, 0, 1, 0, 0, 4'h0, 6'h28);
        vt[27] = mk(0, 1, 0, 0, 16'hFF20, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 6'h28);
        vt[28] = mk(0, 1, 1, 0, 16'hFF21, 8'hF0, 8'h00, 0, 0, 1, 0, 4'hF, 6'h28);
        vt[29] = mk(0, 1, 1, 0, 16'hFF23, 8'h80, 8'h00, 1, 0, 1, 0, 4'hF, 6'h28);
        vt[30] = mk(0, 1, 1, 0, 16'hFF23, 8'h80, 8'h00, 1, 0, 1, 0, 4'hF, 6'h28);
        vt[31] = mk(0, 1, 0, 0, 16'hFF23, 8'h00, 8'h00, 0, 0, 1, 0, 4'hF, 6'h28);

        for (int k = 0; k < 4; k++) m_reg[k] = 8'h00;
        m_start = 1'b0; m_ll = 1'b0; m_rdata = 8'h00;

        // Directed table
        for (int i = 0; i < 32; i++) begin
            reset = vt[i].rst; apu_on = vt[i].apu; wr = vt[i].w; rd = vt[i].r;
            addr = vt[i].a; wdata = vt[i].d;
            tick();
            chk($sformatf("vec%0d rdata", i),   16'(rdata), 16'(vt[i].e_rdata));
            chk($sformatf("vec%0d start", i),   16'(start), 16'(vt[i].e_start));
            chk($sformatf("vec%0d lenload", i), 16'(length_load), 16'(vt[i].e_ll));
            chk($sformatf("vec%0d dac_on", i),  16'(dac_on), 16'(vt[i].e_dac));
            chk($sformatf("vec%0d single", i),  16'(single), 16'(vt[i].e_single));
            chk($sformatf("vec%0d volume", i),  16'(initial_volume), 16'(vt[i].e_vol));
            chk($sformatf("vec%0d length", i),  16'(length), 16'(vt[i].e_len));
            if (i == 3) begin
                chk("vec3 env_inc", 16'(envelope_increasing), 16'd1);
                chk("vec3 sweeps",  16'(num_envelope_sweeps), 16'd1);
            end
        end

        // Trigger write immediately followed by reset: pulse must never show
        // while reset is high, and everything clears.
        reset = 0; apu_on = 1; rd = 0; wr = 1; addr = 16'hFF23; wdata = 8'h80;
        tick();
        wr = 0; reset = 1;
        #1;
        chk("rstcancel start during reset", 16'(start), 16'd0);
        tick();
        chk("rstcancel start after",  16'(start), 16'd0);
        chk("rstcancel dac_on",       16'(dac_on), 16'd0);
        chk("rstcancel volume",       16'(initial_volume), 16'd0);
        chk("rstcancel length",       16'(length), 16'd0);
        chk("rstcancel rdata",        16'(rdata), 16'd0);
        reset = 0;
        tick();
        chk("rstcancel start stays 0", 16'(start), 16'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int sel;
            reset  = ($urandom_range(0, 99) == 0);
            apu_on = ($urandom_range(0, 15) != 0);
            wr     = ($urandom_range(0, 2) != 0);
            rd     = ($urandom_range(0, 1) != 0);
            sel    = $urandom_range(0, 5);
            if (sel < 4)       addr = 16'hFF20 + 16'(sel);
            else if (sel == 4) addr = 16'hFF30;
            else               addr = 16'($urandom);
            wdata = 8'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
